// File: rtl/capture_seq.sv
// Capture sequencer: decimates ADC samples into a circular sample RAM and
// frames PRE_TRIG samples before a level-crossing (or forced) trigger.
module capture_seq #(
    parameter int unsigned DEPTH    = 512,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned PRE_TRIG = 128,
    parameter int unsigned AUTO_TO  = 1023
) (
    input  logic              sampleClock,
    input  logic              resetN,
    input  logic              adcValid,
    input  logic [DATA_W-1:0] adcData,
    input  logic [DATA_W-1:0] trigLevel,
    input  logic              trigRising,
    input  logic              autoMode,
    input  logic              hold,
    input  logic [5:0]        sampleAdjust,
    input  logic              frameAck,
    output logic              ramWe,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [DATA_W-1:0] ramData,
    output logic [ADDR_W-1:0] frameStart,
    output logic              frameReady,
    output logic              trigged,
    output logic [2:0]        state
);

    localparam int unsigned AUTO_W = (AUTO_TO > 0) ? $clog2(AUTO_TO + 1) : 1;

    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRE_TRIG - 2);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_TO);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_READY = 3'd4
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [5:0]          dec_cnt;
    logic [ADDR_W-1:0]   w_addr;
    logic [ADDR_W-1:0]   pre_cnt;
    logic [ADDR_W-1:0]   post_cnt;
    logic [AUTO_W-1:0]   arm_cnt;
    logic [DATA_W-1:0]   prev;
    logic                prev_valid;
    logic [ADDR_W-1:0]   trig_addr;
    logic                trig_real;

    logic                keep_c;
    logic                capture_c;
    logic                edge_c;
    logic                force_c;

    // Sample qualification, trigger detection and next-state selection
    always_comb begin
        state_d   = state_q;
        keep_c    = adcValid && (dec_cnt >= sampleAdjust);
        capture_c = keep_c && (state_q inside {S_PRE, S_ARMED, S_POST});
        edge_c    = 1'b0;
        force_c   = autoMode && (arm_cnt == AUTO_LAST);

        if (prev_valid) begin
            if (trigRising) begin
                edge_c = (prev < trigLevel) && (adcData >= trigLevel);
            end else begin
                edge_c = (prev > trigLevel) && (adcData <= trigLevel);
            end
        end

        case (state_q)
            S_IDLE:  if (!hold) state_d = S_PRE;
            S_PRE:   if (keep_c && (pre_cnt == PRE_LAST)) state_d = S_ARMED;
            S_ARMED: if (keep_c && (edge_c || force_c)) state_d = S_POST;
            S_POST:  if (keep_c && (post_cnt == POST_LAST)) state_d = S_READY;
            S_READY: if (frameAck) state_d = hold ? S_IDLE : S_PRE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sampleClock or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Decimation, RAM write port, frame counters and frame descriptor
    always_ff @(posedge sampleClock or negedge resetN) begin
        if (!resetN) begin
            dec_cnt    <= '0;
            w_addr     <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            arm_cnt    <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            trig_addr  <= '0;
            trig_real  <= 1'b0;
            ramWe      <= 1'b0;
            ramAddr    <= '0;
            ramData    <= '0;
            frameStart <= '0;
            frameReady <= 1'b0;
            trigged    <= 1'b0;
        end else begin
            if (adcValid) begin
                dec_cnt <= keep_c ? 6'd0 : dec_cnt + 6'd1;
            end

            ramWe <= capture_c;
            if (capture_c) begin
                ramAddr    <= w_addr;
                ramData    <= adcData;
                w_addr     <= w_addr + ADDR_W'(1);
                prev       <= adcData;
                prev_valid <= 1'b1;
            end

            case (state_q)
                S_IDLE, S_READY: begin
                    pre_cnt    <= '0;
                    post_cnt   <= '0;
                    arm_cnt    <= '0;
                    prev_valid <= 1'b0;
                end
                S_PRE: if (keep_c) pre_cnt <= pre_cnt + ADDR_W'(1);
                S_ARMED: begin
                    if (keep_c) begin
                        if (edge_c || force_c) begin
                            trig_addr <= w_addr;
                            trig_real <= edge_c;
                        end else if (arm_cnt != AUTO_LAST) begin
                            arm_cnt <= arm_cnt + AUTO_W'(1);
                        end
                    end
                end
                S_POST: if (keep_c) post_cnt <= post_cnt + ADDR_W'(1);
                default: ;
            endcase

            // Frame descriptor is published only as the frame completes
            if ((state_q == S_POST) && (state_d == S_READY)) begin
                frameStart <= trig_addr - PRE_OFS;
                trigged    <= trig_real;
                frameReady <= 1'b1;
            end else if ((state_q == S_READY) && frameAck) begin
                frameReady <= 1'b0;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_capture_seq.sv
// Directed self-checking bench for capture_seq: ramp trigger, decimation with
// address wrap, hold/ack flow, falling edge, auto trigger and async reset.
module tb_capture_seq;

    logic       sampleClock = 1'b0;
    logic       resetN;
    logic       adcValid;
    logic [7:0] adcData;
    logic [7:0] trigLevel;
    logic       trigRising;
    logic       autoMode;
    logic       hold;
    logic [5:0] sampleAdjust;
    logic       frameAck;
    logic       ramWe;
    logic [8:0] ramAddr;
    logic [7:0] ramData;
    logic [8:0] frameStart;
    logic       frameReady;
    logic       trigged;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int wr_base;
    int k;

    capture_seq dut (
        .sampleClock (sampleClock),
        .resetN      (resetN),
        .adcValid    (adcValid),
        .adcData     (adcData),
        .trigLevel   (trigLevel),
        .trigRising  (trigRising),
        .autoMode    (autoMode),
        .hold        (hold),
        .sampleAdjust(sampleAdjust),
        .frameAck    (frameAck),
        .ramWe       (ramWe),
        .ramAddr     (ramAddr),
        .ramData     (ramData),
        .frameStart  (frameStart),
        .frameReady  (frameReady),
        .trigged     (trigged),
        .state       (state)
    );

    always #5 sampleClock = ~sampleClock;

    // Tally of RAM write strobes, sampled shortly after each rising edge
    always @(posedge sampleClock) begin
        #2;
        if (ramWe === 1'b1) wr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        adcValid = v;
        adcData  = d;
        @(negedge sampleClock);
    endtask

    initial begin
        resetN       = 1'b0;
        adcValid     = 1'b0;
        adcData      = 8'h00;
        trigLevel    = 8'h80;
        trigRising   = 1'b1;
        autoMode     = 1'b0;
        hold         = 1'b0;
        sampleAdjust = 6'd0;
        frameAck     = 1'b0;

        @(negedge sampleClock);
        check("rst_state",      32'(state), 0);
        check("rst_ramWe",      32'(ramWe), 0);
        check("rst_frameReady", 32'(frameReady), 0);
        check("rst_frameStart", 32'(frameStart), 0);

        resetN = 1'b1;
        drive(1'b0, 8'h00);
        check("rel_to_pre", 32'(state), 1);

        // Frame 1: full-rate ramp, rising trigger on 0x80
        wr_base = wr_cnt;
        for (int i = 0; i < 512; i++) begin
            drive(1'b1, 8'(i));
            if (i == 0) begin
                check("f1_we0",   32'(ramWe), 1);
                check("f1_addr0", 32'(ramAddr), 0);
            end
            if (i == 127) check("f1_armed", 32'(state), 2);
            if (i == 128) begin
                check("f1_post",     32'(state), 3);
                check("f1_addr_trg", 32'(ramAddr), 128);
                check("f1_data_trg", 32'(ramData), 32'h80);
            end
            if (i == 511) begin
                check("f1_ready",      32'(state), 4);
                check("f1_frameReady", 32'(frameReady), 1);
                check("f1_frameStart", 32'(frameStart), 0);
                check("f1_trigged",    32'(trigged), 1);
                check("f1_addr_last",  32'(ramAddr), 511);
            end
        end
        drive(1'b0, 8'h00);
        drive(1'b0, 8'h00);
        check("f1_hold_ready",  32'(state), 4);
        check("f1_ready_noWe",  32'(ramWe), 0);
        check("f1_write_count", 32'(wr_cnt - wr_base), 512);

        frameAck = 1'b1;
        drive(1'b0, 8'h00);
        frameAck = 1'b0;
        check("f1_ack_pre",   32'(state), 1);
        check("f1_ack_clear", 32'(frameReady), 0);

        // Frame 2: keep 1 of 4, wraps the address, hold raised during POST
        sampleAdjust = 6'd3;
        for (int j = 0; j < 544 * 4; j++) begin
            if (j == 300 * 4) hold = 1'b1;
            drive(1'b1, 8'(j));
            if (j < 8) check("f2_we_pattern", 32'(ramWe), 32'((j % 4) == 3));
            if ((j % 4) == 3) begin
                k = j / 4;
                if (k == 1) begin
                    check("f2_addr1", 32'(ramAddr), 1);
                    check("f2_data1", 32'(ramData), 7);
                end
                if (k == 159) check("f2_armed", 32'(state), 2);
                if (k == 160) begin
                    check("f2_post",     32'(state), 3);
                    check("f2_addr_trg", 32'(ramAddr), 160);
                end
                if (k == 200) check("f2_fs_stable", 32'(frameStart), 0);
                if (k == 511) check("f2_addr511",   32'(ramAddr), 511);
                if (k == 512) check("f2_wrap0",     32'(ramAddr), 0);
                if (k == 543) begin
                    check("f2_ready",      32'(state), 4);
                    check("f2_frameReady", 32'(frameReady), 1);
                    check("f2_frameStart", 32'(frameStart), 32);
                    check("f2_trigged",    32'(trigged), 1);
                end
            end
        end
        drive(1'b0, 8'h00);
        check("f2_still_ready", 32'(state), 4);

        frameAck = 1'b1;
        drive(1'b0, 8'h00);
        frameAck = 1'b0;
        check("hold_ack_idle",  32'(state), 0);
        check("hold_ack_clear", 32'(frameReady), 0);
        wr_base = wr_cnt;
        for (int n = 0; n < 8; n++) drive(1'b1, 8'hAA);
        check("idle_stays",    32'(state), 0);
        check("idle_no_write", 32'(wr_cnt - wr_base), 0);
        hold         = 1'b0;
        sampleAdjust = 6'd0;
        drive(1'b0, 8'h00);
        check("unhold_pre", 32'(state), 1);

        // Frame 3: falling trigger at 0x40, ack during PRE ignored
        trigRising = 1'b0;
        trigLevel  = 8'h40;
        for (int n = 0; n < 128; n++) begin
            frameAck = (n == 10);
            drive(1'b1, 8'h40);
            if (n == 10) check("ack_in_pre", 32'(state), 1);
        end
        frameAck = 1'b0;
        check("fall_armed", 32'(state), 2);
        drive(1'b1, 8'h40);
        drive(1'b1, 8'h40);
        check("fall_equal_none", 32'(state), 2);
        drive(1'b1, 8'h50);
        check("fall_rise_none", 32'(state), 2);
        drive(1'b1, 8'h40);
        check("fall_trig",      32'(state), 3);
        check("fall_trig_addr", 32'(ramAddr), 163);
        for (int n = 0; n < 383; n++) drive(1'b1, 8'h40);
        check("f3_ready",      32'(state), 4);
        check("f3_frameStart", 32'(frameStart), 35);
        check("f3_trigged",    32'(trigged), 1);
        frameAck = 1'b1;
        drive(1'b0, 8'h00);
        frameAck = 1'b0;

        // Frame 4: flat input, auto mode forces the trigger
        trigRising = 1'b1;
        trigLevel  = 8'h80;
        autoMode   = 1'b1;
        for (int n = 0; n < 1535; n++) begin
            drive(1'b1, 8'h10);
            if (n == 1150) check("auto_armed",  32'(state), 2);
            if (n == 1151) check("auto_forced", 32'(state), 3);
        end
        check("auto_ready",      32'(state), 4);
        check("auto_trigged",    32'(trigged), 0);
        check("auto_frameStart", 32'(frameStart), 34);
        check("auto_frameReady", 32'(frameReady), 1);
        frameAck = 1'b1;
        drive(1'b0, 8'h00);
        frameAck = 1'b0;

        // Frame 5: no auto mode, stays armed, then async reset mid-ARMED
        autoMode = 1'b0;
        for (int n = 0; n < 1628; n++) drive(1'b1, 8'h10);
        check("noauto_armed", 32'(state), 2);
        check("noauto_we",    32'(ramWe), 1);

        resetN = 1'b0;
        #1;
        check("arst_state",      32'(state), 0);
        check("arst_ramWe",      32'(ramWe), 0);
        check("arst_ramAddr",    32'(ramAddr), 0);
        check("arst_ramData",    32'(ramData), 0);
        check("arst_frameStart", 32'(frameStart), 0);
        check("arst_frameReady", 32'(frameReady), 0);
        check("arst_trigged",    32'(trigged), 0);
        @(negedge sampleClock);
        resetN = 1'b1;
        drive(1'b1, 8'h22);
        check("post_rst_pre",  32'(state), 1);
        check("post_rst_noWe", 32'(ramWe), 0);
        drive(1'b1, 8'h33);
        check("post_rst_we",   32'(ramWe), 1);
        check("post_rst_addr", 32'(ramAddr), 0);
        check("post_rst_data", 32'(ramData), 32'h33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
